// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-stage definitions: ALUOp codes,
// R-format opcodes, function select and FSM states.
package legv8_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CBZ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_LSL = 11'b11010011011;
  localparam logic [10:0] OPC_LSR = 11'b11010011010;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  typedef enum logic {
    IDLE,
    MUL
  } state_t;

  typedef enum logic [3:0] {
    F_ADD,
    F_SUB,
    F_AND,
    F_ORR,
    F_LSL,
    F_LSR,
    F_MUL,
    F_PASS,
    F_ILL
  } fn_t;

  function automatic fn_t rtype_fn(
    input logic [10:0] opc,
    input logic        mul_en
  );
    fn_t fn;
    case (opc)
      OPC_ADD: fn = F_ADD;
      OPC_SUB: fn = F_SUB;
      OPC_AND: fn = F_AND;
      OPC_ORR: fn = F_ORR;
      OPC_LSL: fn = F_LSL;
      OPC_LSR: fn = F_LSR;
      OPC_MUL: fn = mul_en ? F_MUL : F_ILL;
      default: fn = F_ILL;
    endcase
    return fn;
  endfunction

  function automatic fn_t decode_fn(
    input logic [1:0]  alu_op,
    input logic [10:0] opc,
    input logic        mul_en
  );
    fn_t fn;
    fn = F_ILL;
    unique case (1'b1)
      (alu_op == ALUOP_ADD):   fn = F_ADD;
      (alu_op == ALUOP_CBZ):   fn = F_PASS;
      (alu_op == ALUOP_RTYPE): fn = rtype_fn(opc, mul_en);
      default:                 fn = F_ILL;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// ID/EX request and EX/MEM result handshake bundle
// for the LEGv8 execute stage.
interface ex_stage_pipe_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [10:0]       opcode;
  logic              alu_src;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic [DATA_W-1:0] sign_ext;
  logic [DATA_W-1:0] pc;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] add_result;
  logic              zero;
  logic              illegal;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  modport master (
    output in_valid, alu_op, opcode, alu_src,
    output rd_data_1, rd_data_2, sign_ext, pc,
    output in_tag, out_ready,
    input  in_ready, out_valid, alu_result,
    input  add_result, zero, illegal, out_tag, busy
  );

  modport slave (
    input  in_valid, alu_op, opcode, alu_src,
    input  rd_data_1, rd_data_2, sign_ext, pc,
    input  in_tag, out_ready,
    output in_ready, out_valid, alu_result,
    output add_result, zero, illegal, out_tag, busy
  );
endinterface

// File: rtl/ex_stage_pipe_mul_iter.sv
// Radix-2 shift-add multiplier, one multiplier bit per
// clock; done holds once all DATA_W bits are consumed.
module mul_iter #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;

  assign done    = (cnt_q == CNT_W'(DATA_W));
  assign product = acc_q;

  // bit 0 is consumed on the start edge itself
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= b[0] ? a : '0;
      mcand_q  <= a << 1;
      mplier_q <= b >> 1;
      cnt_q    <= CNT_W'(1);
    end else if (!done && cnt_q != '0) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: rtl/ex_stage_pipe.sv
// LEGv8 execute stage: single-cycle ALU, branch target
// adder and iterative MUL behind a registered handshake.
module ex_stage_pipe
  import legv8_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int MUL_EN = 1
) (
  input logic           clk,
  input logic           rst_n,
  ex_stage_pipe_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  state_t state_q, state_d;
  fn_t    fn;

  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] res_c;
  logic              ill_c;
  logic [DATA_W-1:0] tgt_c;
  logic [DATA_W-1:0] tgt_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] mul_prod;
  logic              mul_done;
  logic              accept;
  logic              is_mul;
  logic              out_free;
  logic              mul_load;

  logic              ov_q;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] add_q;
  logic              zero_q;
  logic              ill_q;
  logic [TAG_W-1:0]  otag_q;

  assign fn       = decode_fn(bus.alu_op, bus.opcode,
                              MUL_EN != 0);
  assign b_op     = bus.alu_src ? bus.sign_ext
                                : bus.rd_data_2;
  assign tgt_c    = bus.pc + (bus.sign_ext << 2);
  assign out_free = !ov_q || bus.out_ready;
  assign is_mul   = (fn == F_MUL);
  assign accept   = bus.in_valid && bus.in_ready;
  assign mul_load = (state_q == MUL) && mul_done
                    && out_free;

  assign bus.in_ready   = (state_q == IDLE) && out_free;
  assign bus.busy       = (state_q == MUL);
  assign bus.out_valid  = ov_q;
  assign bus.alu_result = res_q;
  assign bus.add_result = add_q;
  assign bus.zero       = zero_q;
  assign bus.illegal    = ill_q;
  assign bus.out_tag    = otag_q;

  always_comb begin
    res_c = '0;
    ill_c = 1'b0;
    unique case (fn)
      F_ADD:  res_c = bus.rd_data_1 + b_op;
      F_SUB:  res_c = bus.rd_data_1 - b_op;
      F_AND:  res_c = bus.rd_data_1 & b_op;
      F_ORR:  res_c = bus.rd_data_1 | b_op;
      F_LSL:  res_c = bus.rd_data_1 << b_op[SH_W-1:0];
      F_LSR:  res_c = bus.rd_data_1 >> b_op[SH_W-1:0];
      F_PASS: res_c = b_op;
      F_MUL:  res_c = '0;
      default: ill_c = 1'b1;
    endcase
  end

  mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (bus.rd_data_1),
    .b       (b_op),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (mul_done && out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      res_q   <= '0;
      add_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
      otag_q  <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !is_mul) begin
        ov_q   <= 1'b1;
        res_q  <= res_c;
        zero_q <= (res_c == '0);
        ill_q  <= ill_c;
        add_q  <= tgt_c;
        otag_q <= bus.in_tag;
      end else if (mul_load) begin
        ov_q   <= 1'b1;
        res_q  <= mul_prod;
        zero_q <= (mul_prod == '0);
        ill_q  <= 1'b0;
        add_q  <= tgt_q;
        otag_q <= tag_q;
      end else if (bus.out_ready) begin
        ov_q   <= 1'b0;
      end
      // MUL side data captured at acceptance only
      if (accept) begin
        tag_q <= bus.in_tag;
        tgt_q <= tgt_c;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// Randomized self-checking bench for ex_stage_pipe
// against an arithmetic reference model.
module tb_ex_stage_pipe;
  localparam int DW = 64;
  localparam int TW = 5;

  localparam logic [10:0] K_ADD = 11'b10001011000;
  localparam logic [10:0] K_SUB = 11'b11001011000;
  localparam logic [10:0] K_AND = 11'b10001010000;
  localparam logic [10:0] K_ORR = 11'b10101010000;
  localparam logic [10:0] K_LSL = 11'b11010011011;
  localparam logic [10:0] K_LSR = 11'b11010011010;
  localparam logic [10:0] K_MUL = 11'b10011011000;

  typedef struct {
    logic [1:0]    op;
    logic [10:0]   opc;
    logic          src;
    logic [DW-1:0] a;
    logic [DW-1:0] b2;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [TW-1:0] tag;
  } op_t;

  typedef struct {
    logic [DW-1:0] res;
    logic          ill;
    logic [DW-1:0] tgt;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus ();

  ex_stage_pipe #(
    .DATA_W (DW),
    .TAG_W  (TW),
    .MUL_EN (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic exp_t model(input op_t t);
    exp_t e;
    logic [DW-1:0] bb;
    bb = t.src ? t.imm : t.b2;
    e.tgt = t.pc + t.imm * 4;
    e.tag = t.tag;
    e.ill = 1'b0;
    e.res = '0;
    if (t.op == 2'b00) e.res = t.a + bb;
    else if (t.op == 2'b01) e.res = bb;
    else if (t.op == 2'b10) begin
      case (t.opc)
        K_ADD: e.res = t.a + bb;
        K_SUB: e.res = t.a - bb;
        K_AND: e.res = t.a & bb;
        K_ORR: e.res = t.a | bb;
        K_LSL: e.res = t.a << (bb % DW);
        K_LSR: e.res = t.a >> (bb % DW);
        K_MUL: e.res = t.a * bb;
        default: e.ill = 1'b1;
      endcase
    end else e.ill = 1'b1;
    return e;
  endfunction

  function automatic op_t rand_op(input bit allow_mul);
    op_t t;
    int k;
    k = $urandom_range(0, 9);
    t.op = (k < 2) ? 2'b00 : (k < 4) ? 2'b01 :
           (k < 9) ? 2'b10 : 2'b11;
    case ($urandom_range(0, 7))
      0: t.opc = K_ADD;
      1: t.opc = K_SUB;
      2: t.opc = K_AND;
      3: t.opc = K_ORR;
      4: t.opc = K_LSL;
      5: t.opc = K_LSR;
      6: t.opc = K_MUL;
      default: t.opc = 11'($urandom);
    endcase
    if (!allow_mul && t.opc == K_MUL) t.opc = K_SUB;
    t.a   = {$urandom, $urandom};
    t.b2  = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0)
      t.b2 = DW'($urandom_range(0, 70));
    if ($urandom_range(0, 7) == 0) t.b2 = t.a;
    t.imm = {$urandom, $urandom};
    t.src = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 5) == 0) t.src = 1'b0;
    t.pc  = {$urandom, $urandom};
    t.tag = TW'($urandom);
    return t;
  endfunction

  task automatic drive(input op_t t);
    bus.in_valid  = 1'b1;
    bus.alu_op    = t.op;
    bus.opcode    = t.opc;
    bus.alu_src   = t.src;
    bus.rd_data_1 = t.a;
    bus.rd_data_2 = t.b2;
    bus.sign_ext  = t.imm;
    bus.pc        = t.pc;
    bus.in_tag    = t.tag;
  endtask

  task automatic go_idle();
    bus.in_valid = 1'b0;
  endtask

  function automatic op_t mk(input logic [1:0] op,
    input logic [10:0] opc, input logic [DW-1:0] a,
    input logic [DW-1:0] b2, input logic [TW-1:0] tag);
    op_t t;
    t.op = op; t.opc = opc; t.src = 1'b0;
    t.a = a; t.b2 = b2; t.imm = '0; t.pc = '0;
    t.tag = tag;
    return t;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    drive(rand_op(1'b1));
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got=%b exp=0", bus.busy);
    end
    checks++;
    if (bus.alu_result !== '0 || bus.add_result !== '0) begin
      errors++;
      $display("FAIL rst_results got=%h/%h exp=0/0",
               bus.alu_result, bus.add_result);
    end
    checks++;
    if ({bus.zero, bus.illegal, bus.out_tag} !== '0) begin
      errors++;
      $display("FAIL rst_flags got=%b%b tag=%h exp=0",
               bus.zero, bus.illegal, bus.out_tag);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready);
    end
    go_idle();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    drive(mk(2'b10, K_ADD, 64'd5, 64'd7, 5'd3));
    bus.out_ready = 1'b1;
    @(negedge clk);
    go_idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_result !== 64'd12
        || bus.zero !== 1'b0 || bus.illegal !== 1'b0
        || bus.out_tag !== 5'd3) begin
      errors++;
      $display("FAIL add got v=%b r=%0d z=%b i=%b t=%0d exp 1 12 0 0 3",
               bus.out_valid, bus.alu_result, bus.zero,
               bus.illegal, bus.out_tag);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_cbz();
    op_t t;
    t = mk(2'b01, K_ADD, 64'd99, 64'd0, 5'd7);
    t.pc  = 64'h100;
    t.imm = -64'sd4;
    drive(t);
    @(negedge clk);
    go_idle();
    checks++;
    if (bus.zero !== 1'b1 || bus.alu_result !== '0
        || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL cbz got z=%b r=%h i=%b exp 1 0 0",
               bus.zero, bus.alu_result, bus.illegal);
    end
    checks++;
    if (bus.add_result !== 64'hF0) begin
      errors++;
      $display("FAIL cbz_target got=%h exp=f0", bus.add_result);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      if (i == 0)
        drive(mk(2'b10, 11'h7FF, 64'd5, 64'd5, 5'd1));
      else
        drive(mk(2'b11, K_ADD, 64'd5, 64'd5, 5'd2));
      @(negedge clk);
      go_idle();
      checks++;
      if (bus.alu_result !== '0 || bus.zero !== 1'b1
          || bus.illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal%0d got r=%h z=%b i=%b exp 0 1 1",
                 i, bus.alu_result, bus.zero, bus.illegal);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    op_t  t;
    int   guard;
    for (int c = 0; c < 300; c++) begin
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) drive(rand_op(1'b0));
      else go_idle();
      #1;
      checks++;
      if (bus.out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_valid c=%0d got=%b exp=%b",
                 c, bus.out_valid, q.size() != 0);
      end
      checks++;
      if (bus.in_ready !== (q.size() == 0 || bus.out_ready)) begin
        errors++;
        $display("FAIL rnd_in_ready c=%0d got=%b", c, bus.in_ready);
      end
      if (q.size() != 0 && bus.out_ready) begin
        e = q.pop_front();
        checks++;
        if (bus.alu_result !== e.res || bus.illegal !== e.ill
            || bus.zero !== (e.res == '0)
            || bus.add_result !== e.tgt
            || bus.out_tag !== e.tag) begin
          errors++;
          $display("FAIL rnd_data c=%0d got=%h/%b/%b/%h/%h exp=%h/%b/%b/%h/%h",
                   c, bus.alu_result, bus.illegal, bus.zero,
                   bus.add_result, bus.out_tag, e.res, e.ill,
                   e.res == '0, e.tgt, e.tag);
        end
      end
      if (bus.in_valid && (q.size() == 0 || bus.out_ready)) begin
        t.op = bus.alu_op; t.opc = bus.opcode;
        t.src = bus.alu_src; t.a = bus.rd_data_1;
        t.b2 = bus.rd_data_2; t.imm = bus.sign_ext;
        t.pc = bus.pc; t.tag = bus.in_tag;
        q.push_back(model(t));
      end
      @(negedge clk);
    end
    go_idle();
    bus.out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      void'(q.pop_front());
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    op_t  t[8];
    exp_t e;
    int   bad;
    bad = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      t[i] = mk(2'b10, K_SUB, {$urandom, $urandom},
                {$urandom, $urandom}, TW'(i));
    end
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(t[i]);
      else go_idle();
      #1;
      if (i < 8 && bus.in_ready !== 1'b1) bad++;
      if (i > 0) begin
        e = model(t[i-1]);
        if (bus.out_valid !== 1'b1 || bus.alu_result !== e.res
            || bus.out_tag !== e.tag) bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_stream got bad=%0d exp=0", bad);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_stall();
    op_t  x, y;
    exp_t ex, ey;
    int   bad;
    bad = 0;
    x = mk(2'b10, K_SUB, 64'd100, 64'd1, 5'd10);
    y = mk(2'b10, K_ORR, 64'hF0, 64'h0F, 5'd11);
    ex = model(x);
    ey = model(y);
    bus.out_ready = 1'b1;
    drive(x);
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(y);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.alu_result !== ex.res
          || bus.out_tag !== ex.tag || bus.zero !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got bad=%0d exp=0", bad);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    go_idle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.alu_result !== ey.res
        || bus.out_tag !== ey.tag) begin
      errors++;
      $display("FAIL stall_release got=%h tag=%h exp=%h tag=%h",
               bus.alu_result, bus.out_tag, ey.res, ey.tag);
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    int bad;
    bad = 0;
    bus.out_ready = 1'b1;
    drive(mk(2'b10, K_MUL, 64'hFFFF_FFFF, 64'h10, 5'd9));
    @(negedge clk);
    go_idle();
    bus.rd_data_1 = {$urandom, $urandom};
    bus.rd_data_2 = {$urandom, $urandom};
    bus.in_tag    = 5'd30;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0
          || bus.out_valid !== 1'b0) bad++;
      if (k == 63) bus.out_ready = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy_window got bad=%0d exp=0", bad);
    end
    checks++;
    if (bus.out_valid !== 1'b1
        || bus.alu_result !== 64'hF_FFFF_FFF0) begin
      errors++;
      $display("FAIL mul_result got v=%b r=%h exp 1 ffffffff0",
               bus.out_valid, bus.alu_result);
    end
    checks++;
    if (bus.out_tag !== 5'd9 || bus.busy !== 1'b0
        || bus.illegal !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL mul_status got t=%0d b=%b i=%b z=%b exp 9 0 0 0",
               bus.out_tag, bus.busy, bus.illegal, bus.zero);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0
        || bus.alu_result !== 64'hF_FFFF_FFF0) begin
      errors++;
      $display("FAIL mul_hold got v=%b rdy=%b r=%h",
               bus.out_valid, bus.in_ready, bus.alu_result);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_random();
    op_t  t;
    exp_t e;
    int   cyc;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      t = rand_op(1'b1);
      t.op = 2'b10;
      t.opc = K_MUL;
      if (n == 3) begin
        t.src = 1'b0;
        t.b2 = '0;
      end
      e = model(t);
      drive(t);
      @(negedge clk);
      go_idle();
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != 64) begin
        errors++;
        $display("FAIL mulr_latency n=%0d got=%0d exp=64", n, cyc);
      end
      checks++;
      if (bus.alu_result !== e.res || bus.add_result !== e.tgt
          || bus.zero !== (e.res == '0)
          || bus.out_tag !== e.tag) begin
        errors++;
        $display("FAIL mulr_data n=%0d got=%h/%h exp=%h/%h",
                 n, bus.alu_result, bus.add_result, e.res, e.tgt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_mul();
    int bad;
    bad = 0;
    bus.out_ready = 1'b1;
    drive(mk(2'b10, K_MUL, 64'd3, 64'd5, 5'd4));
    @(negedge clk);
    go_idle();
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmul got busy=%b v=%b exp 0 0",
               bus.busy, bus.out_valid);
    end
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rstmul_ghost got bad=%0d exp=0", bad);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op    = '0;
    bus.opcode    = '0;
    bus.alu_src   = 1'b0;
    bus.rd_data_1 = '0;
    bus.rd_data_2 = '0;
    bus.sign_ext  = '0;
    bus.pc        = '0;
    bus.in_tag    = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_cbz();
    test_illegal();
    test_random();
    test_back_to_back();
    test_stall();
    test_mul();
    test_mul_random();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the operand, result and PC width (power of two, at least 8).
REQ-002 The block SHALL have parameter TAG_W, default 5, giving the width of the pass-through destination tag.
REQ-003 The block SHALL have parameter MUL_EN, default 1; when 0, MUL is treated as an illegal opcode.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid / in_ready  input / output  1 / 1  ID/EX handshake; a transfer occurs when both are 1 at a rising edge.
REQ-007 alu_op, opcode, alu_src  input  2, 11, 1  LEGv8 ALUOp, R-format opcode field, and B-operand select.
REQ-008 rd_data_1, rd_data_2, sign_ext, pc  input  DATA_W each  register operands, extended immediate, instruction PC.
REQ-009 in_tag  input  TAG_W  destination tag, carried unchanged to out_tag.
REQ-010 out_valid / out_ready  output / input  1 / 1  EX/MEM handshake.
REQ-011 alu_result, add_result  output  DATA_W each  registered ALU result and branch target.
REQ-012 zero, illegal, out_tag, busy  output  1, 1, TAG_W, 1  result-is-zero flag, undecoded-op flag, tag, multiply in progress.

Function
REQ-013 B SHALL equal sign_ext when alu_src=1, else rd_data_2.
REQ-014 add_result SHALL equal pc + (sign_ext << 2), truncated to DATA_W bits.
REQ-015 alu_op 00 SHALL select ADD; 01 SHALL select pass-B (CBZ); 10 SHALL decode the opcode field.
REQ-016 Opcode decode SHALL be: 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR, 11010011011 LSL, 11010011010 LSR, 10011011000 MUL.
REQ-017 LSL and LSR SHALL shift A by B[log2(DATA_W)-1:0]; LSR SHALL be a logical shift.
REQ-018 Arithmetic SHALL wrap modulo 2^DATA_W, and MUL SHALL return the low DATA_W bits of the product.
REQ-019 An undecoded opcode, alu_op 11, or MUL with MUL_EN=0 SHALL produce alu_result=0, zero=1, illegal=1.
REQ-020 zero SHALL be 1 exactly when the registered alu_result equals 0.
REQ-021 Non-MUL ops SHALL complete with 1-cycle latency: accepted at edge N, out_valid=1 after edge N.
REQ-022 MUL SHALL be computed by an iterative radix-2 shift-add; the result SHALL load into the output register on the DATA_W-th edge after acceptance, provided the output register is free.
REQ-023 The FSM SHALL have two states, IDLE and MUL; IDLE->MUL on acceptance of MUL; MUL->IDLE when the result loads.
REQ-024 busy SHALL be 1 exactly in state MUL.
REQ-025 If the output register is still held when a MUL finishes, the FSM SHALL stay in MUL with the counter saturated until the register frees.
REQ-026 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-027 While out_valid=1 and out_ready=0, all outputs except in_ready and busy SHALL hold stable.
REQ-028 A simultaneous output drain and input accept SHALL sustain one result per cycle for non-MUL ops.
REQ-029 Inputs SHALL be sampled only at acceptance; later input changes SHALL NOT affect an in-flight MUL.

Reset
REQ-030 While rst_n=0 at an edge, the block SHALL set state=IDLE, out_valid=0, busy=0, alu_result=0, add_result=0, zero=0, illegal=0, out_tag=0, and clear the multiply counter.
REQ-031 Reset during MUL or during an output hold SHALL discard the operation, with no result ever issued.

Structure
REQ-032 The opcode constants, the alu_op encodings and the FSM state enum SHALL live in shared package legv8_pkg.
REQ-033 The iterative multiplier SHALL be one sub-module, mul_iter, with start/done and DATA_W parameter.
REQ-034 The existing 2:1 mux and adder sub-modules MAY be reused for B-select and the branch target.

Verification (DATA_W=64)
REQ-035 ADD, alu_op=10, A=5, B=rd_data_2=7, out_ready=1 -> next cycle alu_result=12, zero=0, illegal=0.
REQ-036 CBZ, alu_op=01, rd_data_2=0, pc=0x100, sign_ext=-4 -> zero=1, add_result=0xF0.
REQ-037 MUL, A=0xFFFFFFFF, B=0x10 -> busy=1, in_ready=0 for 64 cycles, then alu_result=0xFFFFFFFF0, out_tag equal to the accepted tag.
REQ-038 Back-to-back SUB stream with out_ready=1 -> one result per cycle; then out_ready=0 for 3 cycles -> outputs frozen, in_ready=0.
REQ-039 rst_n=0 at MUL cycle 20 -> after the edge busy=0, out_valid=0; no result appears for that MUL.
REQ-040 opcode=11111111111, alu_op=10 -> alu_result=0, zero=1, illegal=1.
